// File: rtl/dmem_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | dmem_pkg: IO register map, control bit positions, base helper   |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
package dmem_pkg;

  localparam logic [2:0] IO_GPIO_OUT   = 3'd0;
  localparam logic [2:0] IO_GPIO_IN    = 3'd1;
  localparam logic [2:0] IO_CYCLE_CNT  = 3'd2;
  localparam logic [2:0] IO_TIMER_CMP  = 3'd3;
  localparam logic [2:0] IO_TIMER_CTRL = 3'd4;
  localparam logic [2:0] IO_TIMER_CNT  = 3'd5;
  localparam logic [2:0] IO_IRQ_STATUS = 3'd6;
  localparam logic [2:0] IO_SCRATCH    = 3'd7;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_AUTO = 1;
  localparam int IRQ_PEND  = 0;

  function automatic int io_base(input int addr_w, input int io_words);
    return (1 << addr_w) - io_words;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | dmem_responder_if: core data-memory port bundle                 |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
interface dmem_responder_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] address_DMEM;
  logic [DATA_W-1:0] write_data_DMEM;
  logic              MemWrite;
  logic              MemRead;
  logic [DATA_W-1:0] data_DMEM;

  modport master (
    output address_DMEM, write_data_DMEM, MemWrite, MemRead,
    input  data_DMEM
  );

  modport slave (
    input  address_DMEM, write_data_DMEM, MemWrite, MemRead,
    output data_DMEM
  );
endinterface
`default_nettype wire

// File: rtl/dmem_timer.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | dmem_timer: compare timer with one-shot/auto-reload and W1C PEND|
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module dmem_timer
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              we_i,
  input  logic [2:0]        off_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] cmp_o,
  output logic [DATA_W-1:0] cnt_o,
  output logic [1:0]        ctrl_o,
  output logic              pend_o
);

  logic [DATA_W-1:0] cmp_q, cmp_d;
  logic [DATA_W-1:0] cnt_q, cnt_d;
  logic              en_q, en_d;
  logic              auto_q, auto_d;
  logic              pend_q, pend_d;
  logic              w_match;

  assign w_match = en_q && (cnt_q == cmp_q);

  // Timer update first, core writes afterwards so they win per register;
  // a match still sets PEND even when the W1C lands in the same cycle.
  always_comb begin
    cmp_d  = cmp_q;
    cnt_d  = cnt_q;
    en_d   = en_q;
    auto_d = auto_q;
    pend_d = pend_q;
    if (en_q) begin
      if (w_match) begin
        pend_d = 1'b1;
        if (auto_q) cnt_d = '0;
        else        en_d  = 1'b0;
      end else begin
        cnt_d = cnt_q + DATA_W'(1);
      end
    end
    if (we_i) begin
      case (off_i)
        IO_TIMER_CMP:  cmp_d = wdata_i;
        IO_TIMER_CTRL: begin
          en_d   = wdata_i[CTRL_EN];
          auto_d = wdata_i[CTRL_AUTO];
        end
        IO_TIMER_CNT:  cnt_d = wdata_i;
        IO_IRQ_STATUS: if (wdata_i[IRQ_PEND] && !w_match) pend_d = 1'b0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cmp_q  <= '0;
      cnt_q  <= '0;
      en_q   <= 1'b0;
      auto_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      cmp_q  <= cmp_d;
      cnt_q  <= cnt_d;
      en_q   <= en_d;
      auto_q <= auto_d;
      pend_q <= pend_d;
    end
  end

  assign cmp_o  = cmp_q;
  assign cnt_o  = cnt_q;
  assign ctrl_o = {auto_q, en_q};
  assign pend_o = pend_q;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | dmem_responder: zero-latency RAM + IO register responder        |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int IO_WORDS = 8,
  parameter int GPIO_W   = 8
) (
  input  logic              CLK,
  input  logic              RSTn,
  dmem_responder_if.slave   bus,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              timer_irq
);

  localparam int IO_BASE = io_base(ADDR_W, IO_WORDS);

  logic [DATA_W-1:0] mem_q [0:IO_BASE-1];
  logic [GPIO_W-1:0] gpio_out_q;
  logic [GPIO_W-1:0] sync1_q, sync2_q;
  logic [DATA_W-1:0] cyc_q;
  logic [DATA_W-1:0] scratch_q;

  logic              w_is_io;
  logic [ADDR_W-1:0] w_off;
  logic              w_io_sel;
  logic [2:0]        w_reg;
  logic              w_io_we;
  logic [DATA_W-1:0] w_tmr_cmp, w_tmr_cnt, w_rdata;
  logic [1:0]        w_tmr_ctrl;
  logic              w_pend;

  assign w_is_io  = bus.address_DMEM >= ADDR_W'(IO_BASE);
  assign w_off    = bus.address_DMEM - ADDR_W'(IO_BASE);
  // Only the eight defined registers decode; any extra IO words read 0.
  assign w_io_sel = w_is_io && (w_off < ADDR_W'(8));
  assign w_reg    = w_off[2:0];
  assign w_io_we  = bus.MemWrite && w_io_sel;

  always_ff @(posedge CLK) begin
    if (bus.MemWrite && !w_is_io) mem_q[bus.address_DMEM] <= bus.write_data_DMEM;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      gpio_out_q <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      cyc_q      <= '0;
      scratch_q  <= '0;
    end else begin
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
      cyc_q   <= cyc_q + DATA_W'(1);
      if (w_io_we && w_reg == IO_GPIO_OUT) gpio_out_q <= bus.write_data_DMEM[GPIO_W-1:0];
      if (w_io_we && w_reg == IO_SCRATCH)  scratch_q  <= bus.write_data_DMEM;
    end
  end

  dmem_timer #(.DATA_W(DATA_W)) u_timer (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .we_i    (w_io_we),
    .off_i   (w_reg),
    .wdata_i (bus.write_data_DMEM),
    .cmp_o   (w_tmr_cmp),
    .cnt_o   (w_tmr_cnt),
    .ctrl_o  (w_tmr_ctrl),
    .pend_o  (w_pend)
  );

  always_comb begin
    w_rdata = '0;
    if (bus.MemRead) begin
      if (!w_is_io) begin
        w_rdata = mem_q[bus.address_DMEM];
      end else if (w_io_sel) begin
        case (w_reg)
          IO_GPIO_OUT:   w_rdata[GPIO_W-1:0] = gpio_out_q;
          IO_GPIO_IN:    w_rdata[GPIO_W-1:0] = sync2_q;
          IO_CYCLE_CNT:  w_rdata = cyc_q;
          IO_TIMER_CMP:  w_rdata = w_tmr_cmp;
          IO_TIMER_CTRL: w_rdata[1:0] = w_tmr_ctrl;
          IO_TIMER_CNT:  w_rdata = w_tmr_cnt;
          IO_IRQ_STATUS: w_rdata[IRQ_PEND] = w_pend;
          default:       w_rdata = scratch_q;
        endcase
      end
    end
  end

  assign bus.data_DMEM = w_rdata;
  assign gpio_out      = gpio_out_q;
  assign timer_irq     = w_pend;

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_dmem_responder: directed scoreboard bench for dmem_responder |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module tb_dmem_responder;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic        timer_irq;

  int          n_cmp = 0;
  int          n_mis = 0;
  logic [31:0] m_cyc;
  string       tagq[$];
  logic [31:0] expq[$];

  dmem_responder_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  dmem_responder #(.ADDR_W(10), .DATA_W(32), .IO_WORDS(8), .GPIO_W(8)) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .bus       (bus),
    .gpio_in   (gpio_in),
    .gpio_out  (gpio_out),
    .timer_irq (timer_irq)
  );

  always #5 CLK = ~CLK;

  // Reference cycle counter: counts edges since the last reset release.
  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) m_cyc <= '0;
    else       m_cyc <= m_cyc + 32'd1;
  end

  task automatic sb_push(input string tag, input logic [31:0] e);
    tagq.push_back(tag);
    expq.push_back(e);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    n_cmp++;
    if (expq.size() == 0) begin
      n_mis++;
      $error("FAIL sb_empty obs=%h exp=none", obs);
    end else begin
      t = tagq.pop_front();
      e = expq.pop_front();
      assert (obs === e) else begin
        n_mis++;
        $error("FAIL %s obs=%h exp=%h", t, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    bus.address_DMEM    = a;
    bus.write_data_DMEM = d;
    bus.MemWrite        = 1'b1;
    bus.MemRead         = 1'b0;
    tick();
    bus.MemWrite = 1'b0;
  endtask

  task automatic rd(input logic [9:0] a, input logic [31:0] e, input logic en, input string tag);
    bus.address_DMEM = a;
    bus.MemRead      = en;
    bus.MemWrite     = 1'b0;
    sb_push(tag, e);
    @(negedge CLK);
    sb_check(bus.data_DMEM);
    tick();
    bus.MemRead = 1'b0;
  endtask

  task automatic rd_now(input logic [9:0] a, input logic [31:0] e, input string tag);
    bus.address_DMEM = a;
    bus.MemRead      = 1'b1;
    bus.MemWrite     = 1'b0;
    sb_push(tag, e);
    #1;
    sb_check(bus.data_DMEM);
    bus.MemRead = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] e);
    sb_push(tag, e);
    sb_check(obs);
  endtask

  initial begin
    bus.address_DMEM    = '0;
    bus.write_data_DMEM = '0;
    bus.MemWrite        = 1'b0;
    bus.MemRead         = 1'b0;
    gpio_in             = 8'h00;

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_irq", {31'd0, timer_irq}, 32'd0);
    chk("rst_gpio_out", {24'd0, gpio_out}, 32'd0);
    rd_now(10'd1018, 32'd0, "rst_cyc");
    @(negedge CLK);
    RSTn = 1'b1;
    tick();
    rd(10'd1018, 32'd1, 1'b1, "cyc_first");

    // RAM
    wr(10'd6, 32'h0000_0001);
    wr(10'd5, 32'hDEAD_BEEF);
    rd(10'd5, 32'hDEAD_BEEF, 1'b1, "ram5");
    rd(10'd5, 32'd0, 1'b0, "ram_noread");
    rd(10'd6, 32'h1, 1'b1, "ram6");

    // Read during write
    wr(10'd9, 32'h11);
    bus.address_DMEM    = 10'd9;
    bus.write_data_DMEM = 32'h22;
    bus.MemWrite        = 1'b1;
    bus.MemRead         = 1'b1;
    sb_push("rdw_old", 32'h11);
    @(negedge CLK);
    sb_check(bus.data_DMEM);
    tick();
    bus.MemWrite = 1'b0;
    sb_push("rdw_new", 32'h22);
    @(negedge CLK);
    sb_check(bus.data_DMEM);
    tick();
    bus.MemRead = 1'b0;

    // GPIO, scratch, cycle counter
    wr(10'd1016, 32'hFFFF_FFA5);
    chk("gpio_out", {24'd0, gpio_out}, 32'hA5);
    rd(10'd1016, 32'hA5, 1'b1, "gpio_rd");
    gpio_in = 8'h3C;
    rd(10'd1017, 32'h00, 1'b1, "gpio_in_e0");
    rd(10'd1017, 32'h00, 1'b1, "gpio_in_e1");
    rd(10'd1017, 32'h3C, 1'b1, "gpio_in_e2");
    wr(10'd1017, 32'hFF);
    rd(10'd1017, 32'h3C, 1'b1, "gpio_in_ro");
    wr(10'd1023, 32'h1234_5678);
    rd(10'd1023, 32'h1234_5678, 1'b1, "scratch");
    wr(10'd1018, 32'd0);
    rd(10'd1018, m_cyc, 1'b1, "cyc_wr_ign");

    // One-shot timer
    wr(10'd1019, 32'd3);
    wr(10'd1021, 32'd0);
    wr(10'd1020, 32'd1);
    rd(10'd1021, 32'd0, 1'b1, "os_cnt0");
    rd(10'd1021, 32'd1, 1'b1, "os_cnt1");
    rd(10'd1021, 32'd2, 1'b1, "os_cnt2");
    chk("os_irq_pre", {31'd0, timer_irq}, 32'd0);
    rd(10'd1021, 32'd3, 1'b1, "os_cnt3");
    chk("os_irq", {31'd0, timer_irq}, 32'd1);
    rd(10'd1022, 32'd1, 1'b1, "os_pend");
    rd(10'd1020, 32'd0, 1'b1, "os_en_clr");
    rd(10'd1021, 32'd3, 1'b1, "os_cnt_hold");
    wr(10'd1022, 32'd1);
    chk("os_w1c", {31'd0, timer_irq}, 32'd0);

    // Auto-reload, period CMP+1 = 3
    wr(10'd1019, 32'd2);
    wr(10'd1021, 32'd0);
    wr(10'd1020, 32'd3);
    tick();
    tick();
    chk("ar_pre", {31'd0, timer_irq}, 32'd0);
    rd(10'd1021, 32'd2, 1'b1, "ar_cnt2");
    chk("ar_m1", {31'd0, timer_irq}, 32'd1);
    rd(10'd1021, 32'd0, 1'b1, "ar_reload");
    wr(10'd1022, 32'd1);
    chk("ar_clr", {31'd0, timer_irq}, 32'd0);
    wr(10'd1022, 32'd1);
    chk("ar_set_wins", {31'd0, timer_irq}, 32'd1);
    wr(10'd1022, 32'd1);
    chk("ar_clr_late", {31'd0, timer_irq}, 32'd0);
    tick();
    chk("ar_pre2", {31'd0, timer_irq}, 32'd0);
    tick();
    chk("ar_m3", {31'd0, timer_irq}, 32'd1);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 200 && m_cyc < 32'd50; i++) tick();
    rd(10'd1018, m_cyc, 1'b1, "cyc_before_rst");
    RSTn = 1'b0;
    #1;
    chk("mid_rst_irq", {31'd0, timer_irq}, 32'd0);
    chk("mid_rst_gpio", {24'd0, gpio_out}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      logic [9:0] a;
      a = 10'(1016 + i);
      rd_now(a, 32'd0, "mid_rst_io");
    end
    rd_now(10'd5, 32'hDEAD_BEEF, "mid_rst_ram");
    @(negedge CLK);
    RSTn = 1'b1;
    tick();
    rd(10'd1018, 32'd1, 1'b1, "cyc_after_rst");

    chk("sb_drain", 32'(expq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
